mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 98 +++++++++
 tb/tb_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one combinational-read memory between instruction fetch and data access.
// Each access takes an ACC cycle (memory driven) followed by an RSP cycle (ready pulse, registered data).
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic [15:0] mem_a,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_out,
  output logic [1:0]  gnt
);

  localparam int CW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;

  typedef enum logic [2:0] {IDLE, ACC_I, ACC_D, RSP_I, RSP_D} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   starve_cnt_reg;
  logic            starved;

  assign starved = (starve_cnt_reg == CW'(STARVE_MAX));

  // A requester is never re-granted straight from its own RSP state, so a
  // request still held during its ready pulse is not serviced twice.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (if_req && (!d_req || starved)) state_next = ACC_I;
        else if (d_req)                    state_next = ACC_D;
      end
      ACC_I:   state_next = RSP_I;
      ACC_D:   state_next = RSP_D;
      RSP_I:   state_next = d_req  ? ACC_D : IDLE;
      RSP_D:   state_next = if_req ? ACC_I : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode from the state register alone, so the asynchronous reset
  // removes the write enable immediately rather than at the next edge.
  always_comb begin
    mem_a    = '0;
    mem_we   = 1'b0;
    mem_wd   = '0;
    gnt      = 2'b00;
    if_ready = 1'b0;
    d_ready  = 1'b0;
    case (state_reg)
      ACC_I: begin
        mem_a = if_addr;
        gnt   = 2'b01;
      end
      ACC_D: begin
        mem_a  = d_addr;
        mem_we = d_we;
        mem_wd = d_wdata;
        gnt    = 2'b10;
      end
      RSP_I:   if_ready = 1'b1;
      RSP_D:   d_ready  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= '0;
      if_rdata       <= '0;
      d_rdata        <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ACC_I) if_rdata <= mem_out;
      if (state_reg == ACC_D) d_rdata  <= mem_out;
      // ACC states never repeat back to back, so a next state of ACC_x is always an entry.
      if (!if_req)
        starve_cnt_reg <= '0;
      else if (state_next == ACC_I)
        starve_cnt_reg <= '0;
      else if (state_next == ACC_D && !starved)
        starve_cnt_reg <= starve_cnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// checked against a rule-level arbitration and memory model.
module tb_mem_arbiter;
  localparam int SM = 4;

  logic        clk, rst;
  logic        if_req, if_ready, d_req, d_we, d_ready, mem_we;
  logic [15:0] if_addr, d_addr, mem_a;
  logic [31:0] if_rdata, d_wdata, d_rdata, mem_wd, mem_out;
  logic [1:0]  gnt;

  int passed = 0;
  int total  = 0;

  logic [31:0] mem [0:63];
  logic        pre_we;
  logic [5:0]  pre_idx;
  logic [31:0] pre_data;

  mem_arbiter #(.STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_out(mem_out), .gnt(gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_out = mem[mem_a[7:2]];
  always @(posedge clk) begin
    if (mem_we)      mem[mem_a[7:2]] <= mem_wd;
    else if (pre_we) mem[pre_idx]    <= pre_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    pre_we = 1'b1; pre_idx = idx; pre_data = data;
    step();
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    pre_we = 0; pre_idx = 0; pre_data = 0;
    step();
    for (int i = 0; i < 64; i++) preload(6'(i), $urandom);
    if_req = 1'b1; d_req = 1'b1;
    step();
    total++; if (gnt !== 2'b00) $display("FAIL reset_gnt got %b want 00", gnt); else passed++;
    total++; if (mem_a !== 16'h0 || mem_we !== 1'b0 || mem_wd !== 32'h0)
      $display("FAIL reset_mem got a=%h we=%b wd=%h want 0", mem_a, mem_we, mem_wd); else passed++;
    total++; if (if_ready !== 1'b0 || d_ready !== 1'b0)
      $display("FAIL reset_ready got %b%b want 00", if_ready, d_ready); else passed++;
    total++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0)
      $display("FAIL reset_rdata got %h %h want 0", if_rdata, d_rdata); else passed++;
    if_req = 1'b0; d_req = 1'b0;
    rst = 1'b0;
    step();
    total++; if (gnt !== 2'b00) $display("FAIL idle_gnt got %b want 00", gnt); else passed++;
    $display("txn reset done");
  endtask

  task automatic test_fetch();
    preload(6'd2, 32'h0000_0013);
    if_req = 1'b1; if_addr = 16'h0008;
    step();
    total++; if (gnt !== 2'b01 || mem_a !== 16'h0008 || mem_we !== 1'b0)
      $display("FAIL fetch_acc got gnt=%b a=%h we=%b want 01 0008 0", gnt, mem_a, mem_we); else passed++;
    step();
    total++; if (if_ready !== 1'b1 || if_rdata !== 32'h0000_0013)
      $display("FAIL fetch_rsp got rdy=%b data=%h want 1 00000013", if_ready, if_rdata); else passed++;
    if_req = 1'b0;
    step();
    total++; if (if_ready !== 1'b0 || gnt !== 2'b00 || if_rdata !== 32'h0000_0013)
      $display("FAIL fetch_after got rdy=%b gnt=%b data=%h want 0 00 00000013", if_ready, gnt, if_rdata); else passed++;
    $display("txn fetch addr=0008 data=%h", if_rdata);
  endtask

  task automatic test_store_load();
    logic [31:0] old;
    old = mem[4];
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0010; d_wdata = 32'hDEAD_BEEF;
    step();
    total++; if (gnt !== 2'b10 || mem_we !== 1'b1 || mem_a !== 16'h0010 || mem_wd !== 32'hDEAD_BEEF)
      $display("FAIL store_acc got gnt=%b we=%b a=%h wd=%h", gnt, mem_we, mem_a, mem_wd); else passed++;
    step();
    total++; if (d_ready !== 1'b1 || mem_we !== 1'b0 || d_rdata !== old || mem[4] !== 32'hDEAD_BEEF)
      $display("FAIL store_rsp got rdy=%b we=%b rdata=%h mem=%h want 1 0 %h deadbeef",
               d_ready, mem_we, d_rdata, mem[4], old); else passed++;
    $display("txn store addr=0010 data=deadbeef");
    d_we = 1'b0;
    step();
    step();
    step();
    total++; if (d_ready !== 1'b1 || d_rdata !== 32'hDEAD_BEEF)
      $display("FAIL load_rsp got rdy=%b data=%h want 1 deadbeef", d_ready, d_rdata); else passed++;
    d_req = 1'b0;
    step();
    $display("txn load addr=0010 data=%h", d_rdata);
  endtask

  task automatic test_simultaneous();
    logic [31:0] seen [4];
    if_req = 1'b1; if_addr = 16'h0040; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0044;
    for (int k = 0; k < 4; k++) begin
      step();
      seen[k] = {28'h0, gnt, if_ready, d_ready};
      if (d_ready) d_req = 1'b0;
      if (if_ready) begin
        if_req = 1'b0;
        total++; if (if_rdata !== mem[16]) $display("FAIL simul_idata got %h want %h", if_rdata, mem[16]); else passed++;
      end
      if (k == 1) begin
        total++; if (d_rdata !== mem[17]) $display("FAIL simul_ddata got %h want %h", d_rdata, mem[17]); else passed++;
      end
    end
    total++; if (seen[0] !== 32'h8 || seen[1] !== 32'h1 || seen[2] !== 32'h4 || seen[3] !== 32'h2)
      $display("FAIL simul_order got %h %h %h %h want 8 1 4 2", seen[0], seen[1], seen[2], seen[3]); else passed++;
    step();
    $display("txn simultaneous data-then-fetch");
  endtask

  task automatic test_starve();
    int dgrants = 0;
    bit got_fetch = 0;
    if_req = 1'b1; if_addr = 16'h0004; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0008;
    for (int k = 0; k < 40 && !got_fetch; k++) begin
      step();
      if (gnt == 2'b10) dgrants++;
      if (gnt == 2'b01) got_fetch = 1;
    end
    total++; if (!got_fetch || dgrants > SM)
      $display("FAIL starve_bound got fetch=%0d dgrants=%0d want 1 <=%0d", got_fetch, dgrants, SM); else passed++;
    total++; if (dut.starve_cnt_reg !== '0)
      $display("FAIL starve_clear got %0d want 0", dut.starve_cnt_reg); else passed++;
    if_req = 1'b0; d_req = 1'b0;
    step(); step(); step();
    $display("txn starve data_grants=%0d", dgrants);
  endtask

  task automatic test_reset_mid();
    logic [31:0] old;
    old = mem[8];
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 32'h1234_5678;
    step();
    total++; if (mem_we !== 1'b1) $display("FAIL rmid_acc got we=%b want 1", mem_we); else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if (mem_we !== 1'b0 || gnt !== 2'b00 || mem_a !== 16'h0 || d_rdata !== 32'h0)
      $display("FAIL rmid_async got we=%b gnt=%b a=%h rdata=%h want 0", mem_we, gnt, mem_a, d_rdata); else passed++;
    d_req = 1'b0; d_we = 1'b0;
    step();
    total++; if (mem[8] !== old || d_ready !== 1'b0)
      $display("FAIL rmid_nowrite got mem=%h rdy=%b want %h 0", mem[8], d_ready, old); else passed++;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (d_ready !== 1'b0 || gnt !== 2'b00)
        $display("FAIL rmid_noready got rdy=%b gnt=%b want 0 00", d_ready, gnt); else passed++;
    end
    $display("txn reset mid-access discarded");
  endtask

  task automatic test_held();
    int pulses = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0030;
    for (int k = 0; k < 12; k++) begin
      step();
      if (d_ready) pulses++;
      total++;
      if (gnt !== ((k % 3 == 0) ? 2'b10 : 2'b00) || d_ready !== (k % 3 == 1))
        $display("FAIL held_seq cycle=%0d got gnt=%b rdy=%b want %b %b",
                 k, gnt, d_ready, (k % 3 == 0) ? 2'b10 : 2'b00, (k % 3 == 1));
      else passed++;
    end
    total++; if (pulses !== 4) $display("FAIL held_pulses got %0d want 4", pulses); else passed++;
    d_req = 1'b0;
    step(); step();
    $display("txn held request pulses=%0d", pulses);
  endtask

  task automatic test_random();
    logic [1:0]  prev_gnt = 2'b00, exp_gnt;
    bit          prev_ifr = 0, prev_dr = 0, e_if, e_d, exp_ifr, exp_dr;
    int          cnt = 0;
    logic [31:0] exp_if_data = 32'h0, exp_d_data = 32'h0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      e_if = if_req; e_d = d_req;
      exp_ifr = (prev_gnt == 2'b01);
      exp_dr  = (prev_gnt == 2'b10);
      if (prev_gnt != 2'b00)  exp_gnt = 2'b00;
      else if (prev_ifr)      exp_gnt = e_d  ? 2'b10 : 2'b00;
      else if (prev_dr)       exp_gnt = e_if ? 2'b01 : 2'b00;
      else if (e_if && (!e_d || cnt == SM)) exp_gnt = 2'b01;
      else                    exp_gnt = e_d ? 2'b10 : 2'b00;
      if (!e_if || exp_gnt == 2'b01) cnt = 0;
      else if (exp_gnt == 2'b10 && cnt < SM) cnt++;
      step();
      total++; if (gnt !== exp_gnt || if_ready !== exp_ifr || d_ready !== exp_dr)
        $display("FAIL rand_ctrl cycle=%0d got gnt=%b ir=%b dr=%b want %b %b %b",
                 cyc, gnt, if_ready, d_ready, exp_gnt, exp_ifr, exp_dr); else passed++;
      if (exp_ifr) begin
        total++; if (if_rdata !== exp_if_data) $display("FAIL rand_idata got %h want %h", if_rdata, exp_if_data); else passed++;
        $display("txn rand fetch data=%h", if_rdata);
      end
      if (exp_dr) begin
        total++; if (d_rdata !== exp_d_data) $display("FAIL rand_ddata got %h want %h", d_rdata, exp_d_data); else passed++;
        $display("txn rand data data=%h", d_rdata);
      end
      if (exp_gnt == 2'b01) begin
        total++; if (mem_a !== if_addr || mem_we !== 1'b0)
          $display("FAIL rand_iacc got a=%h we=%b want %h 0", mem_a, mem_we, if_addr); else passed++;
        exp_if_data = mem[if_addr[7:2]];
      end
      if (exp_gnt == 2'b10) begin
        total++; if (mem_a !== d_addr || mem_we !== d_we || (d_we && mem_wd !== d_wdata))
          $display("FAIL rand_dacc got a=%h we=%b wd=%h want %h %b %h", mem_a, mem_we, mem_wd, d_addr, d_we, d_wdata); else passed++;
        exp_d_data = mem[d_addr[7:2]];
      end
      prev_gnt = exp_gnt; prev_ifr = exp_ifr; prev_dr = exp_dr;
      // requesters: hold until ready, sometimes re-issue at once, occasionally withdraw before a grant
      if (exp_ifr || !if_req) begin
        if_req  = ($urandom_range(0, 2) == 0);
        if_addr = {8'h00, 6'($urandom_range(0, 63)), 2'b00};
      end else if (exp_gnt != 2'b01 && $urandom_range(0, 15) == 0) if_req = 1'b0;
      if (exp_dr || !d_req) begin
        d_req   = ($urandom_range(0, 1) == 0);
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = {8'h00, 6'($urandom_range(0, 63)), 2'b00};
        d_wdata = $urandom;
      end else if (exp_gnt != 2'b10 && $urandom_range(0, 15) == 0) d_req = 1'b0;
    end
    if_req = 1'b0; d_req = 1'b0;
    step(); step(); step();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_load();
    test_simultaneous();
    test_starve();
    test_reset_mid();
    test_held();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
